// File: rtl/collision_pkg.sv
// Types and sizing for the T-rex vs. obstacle collision scanner.
package collision_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned INSET_DEFAULT = 2;
  localparam int unsigned XPOS_W        = 11;
  localparam int unsigned COORD_W       = 10;
  localparam int unsigned ARITH_W       = 13;
  localparam int unsigned IDX_W         = 3;

  // Screen box: signed left edge, unsigned top edge and size.
  typedef struct packed {
    logic [XPOS_W-1:0]  x;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] w;
    logic [COORD_W-1:0] h;
  } box_t;
endpackage

// File: rtl/horizon_pkg.sv
// Game-wide sizing shared by the horizon and its consumers.
package horizon_pkg;
  localparam int unsigned MAX_OBSTACLES = 7;
endpackage

// File: rtl/box_overlap.sv
// Combinational overlap test of two boxes, each shrunk by INSET on every side.
module box_overlap
  import collision_pkg::*;
#(
  parameter int unsigned INSET = INSET_DEFAULT
) (
  input  box_t a,
  input  box_t b,
  output logic hit_c
);
  typedef logic signed [ARITH_W-1:0] arith_t;

  localparam arith_t INS  = arith_t'(INSET);
  localparam arith_t INS2 = arith_t'(2 * INSET);

  function automatic arith_t left_edge(input logic [XPOS_W-1:0] x);
    return $signed({{(ARITH_W-XPOS_W){x[XPOS_W-1]}}, x}) + INS;
  endfunction

  function automatic arith_t top_edge(input logic [COORD_W-1:0] y);
    return $signed({{(ARITH_W-COORD_W){1'b0}}, y}) + INS;
  endfunction

  // Size minus both insets, floored at zero.
  function automatic arith_t inset_size(input logic [COORD_W-1:0] s);
    arith_t v;
    v = $signed({{(ARITH_W-COORD_W){1'b0}}, s}) - INS2;
    return v[ARITH_W-1] ? '0 : v;
  endfunction

  arith_t ax, ay, aw, ah;
  arith_t bx, by, bw, bh;

  assign ax = left_edge(a.x);
  assign ay = top_edge(a.y);
  assign aw = inset_size(a.w);
  assign ah = inset_size(a.h);
  assign bx = left_edge(b.x);
  assign by = top_edge(b.y);
  assign bw = inset_size(b.w);
  assign bh = inset_size(b.h);

  // Degenerate boxes are excluded explicitly; strict compares alone would let a
  // zero-size box inside the other one report a hit.
  always_comb begin
    hit_c = (aw != '0) && (ah != '0) && (bw != '0) && (bh != '0) &&
            (ax < bx + bw) && (bx < ax + aw) &&
            (ay < by + bh) && (by < ay + ah);
  end
endmodule

// File: rtl/collision_scanner.sv
// Sequentially scans obstacle slots against a snapshot of the T-rex box and
// raises a sticky crash flag on the lowest-index overlap.
module collision_scanner
  import collision_pkg::*;
#(
  parameter int unsigned N_SLOTS = horizon_pkg::MAX_OBSTACLES,
  parameter int unsigned INSET   = INSET_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      scan,
  input  logic                      clear,
  input  logic signed [XPOS_W-1:0]  trex_x_pos,
  input  logic        [COORD_W-1:0] trex_y_pos,
  input  logic        [COORD_W-1:0] trex_width,
  input  logic        [COORD_W-1:0] trex_height,
  input  logic                      obstacle_start  [N_SLOTS],
  input  logic signed [XPOS_W-1:0]  obstacle_x_pos  [N_SLOTS],
  input  logic        [COORD_W-1:0] obstacle_y_pos  [N_SLOTS],
  input  logic        [COORD_W-1:0] obstacle_width  [N_SLOTS],
  input  logic        [COORD_W-1:0] obstacle_height [N_SLOTS],
  output logic                      busy,
  output logic                      done,
  output logic                      crash,
  output logic        [IDX_W-1:0]   hit_index
);
  state_t           state, next_state;
  logic [IDX_W-1:0] idx, idx_d;
  box_t             trex_q, trex_d, trex_in, slot_box;
  logic             slot_start, geo_hit_c, slot_hit_c, last_slot, accept_c;
  logic             busy_d, done_d, crash_d;
  logic [IDX_W-1:0] hit_d;

  assign trex_in = '{x: trex_x_pos, y: trex_y_pos, w: trex_width, h: trex_height};

  // Select the live obstacle addressed by idx.
  always_comb begin
    slot_start = 1'b0;
    slot_box   = '0;
    for (int unsigned i = 0; i < N_SLOTS; i++) begin
      if (idx == IDX_W'(i)) begin
        slot_start = obstacle_start[i];
        slot_box   = '{x: obstacle_x_pos[i], y: obstacle_y_pos[i],
                       w: obstacle_width[i], h: obstacle_height[i]};
      end
    end
  end

  box_overlap #(.INSET(INSET)) u_overlap (
    .a     (trex_q),
    .b     (slot_box),
    .hit_c (geo_hit_c)
  );

  assign slot_hit_c = slot_start && geo_hit_c;
  assign last_slot  = (idx == IDX_W'(N_SLOTS - 1));
  assign accept_c   = (state == IDLE) && scan && !crash && !clear;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; clear aborts any scan.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: if (accept_c) next_state = SCAN;
      SCAN: begin
        if (clear) begin
          next_state = IDLE;
        end else if (slot_hit_c || last_slot) begin
          next_state = DONE;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Next values of the registered outputs and datapath.
  always_comb begin
    busy_d  = (next_state != IDLE);
    done_d  = (next_state == DONE);
    crash_d = crash;
    hit_d   = hit_index;
    idx_d   = idx;
    trex_d  = trex_q;
    if (clear) begin
      crash_d = 1'b0;
      hit_d   = '0;
      idx_d   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept_c) begin
            idx_d  = '0;
            trex_d = trex_in;
          end
        end
        SCAN: begin
          if (slot_hit_c) begin
            crash_d = 1'b1;
            hit_d   = idx;
          end else if (!last_slot) begin
            idx_d = idx + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx       <= '0;
      trex_q    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      crash     <= 1'b0;
      hit_index <= '0;
    end else begin
      idx       <= idx_d;
      trex_q    <= trex_d;
      busy      <= busy_d;
      done      <= done_d;
      crash     <= crash_d;
      hit_index <= hit_d;
    end
  end
endmodule

// File: tb/tb_collision_scanner.sv
// Directed, table-driven bench for collision_scanner.
module tb_collision_scanner;
  localparam int N  = 7;
  localparam int NV = 14;

  logic               clk = 1'b0;
  logic               rst, scan, clear;
  logic signed [10:0] trex_x_pos;
  logic        [9:0]  trex_y_pos, trex_width, trex_height;
  logic               obstacle_start  [N];
  logic signed [10:0] obstacle_x_pos  [N];
  logic        [9:0]  obstacle_y_pos  [N];
  logic        [9:0]  obstacle_width  [N];
  logic        [9:0]  obstacle_height [N];
  logic               busy, done, crash;
  logic        [2:0]  hit_index;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string name;
    int tx, ty, tw, th;
    int sa, ax, ay, aw, ah;
    int sb, bx, by, bw, bh;
    int exp_crash, exp_idx, exp_lat;
  } vec_t;

  vec_t vecs [NV];

  collision_scanner dut (
    .clk             (clk),
    .rst             (rst),
    .scan            (scan),
    .clear           (clear),
    .trex_x_pos      (trex_x_pos),
    .trex_y_pos      (trex_y_pos),
    .trex_width      (trex_width),
    .trex_height     (trex_height),
    .obstacle_start  (obstacle_start),
    .obstacle_x_pos  (obstacle_x_pos),
    .obstacle_y_pos  (obstacle_y_pos),
    .obstacle_width  (obstacle_width),
    .obstacle_height (obstacle_height),
    .busy            (busy),
    .done            (done),
    .crash           (crash),
    .hit_index       (hit_index)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Inactive slots carry a box that would overlap the default T-rex.
  task automatic default_slots();
    for (int i = 0; i < N; i++) begin
      obstacle_start[i]  = 1'b0;
      obstacle_x_pos[i]  = 11'(60);
      obstacle_y_pos[i]  = 10'(110);
      obstacle_width[i]  = 10'(17);
      obstacle_height[i] = 10'(35);
    end
  endtask

  task automatic set_trex(input int x, input int y, input int w, input int h);
    trex_x_pos  = 11'(x);
    trex_y_pos  = 10'(y);
    trex_width  = 10'(w);
    trex_height = 10'(h);
  endtask

  task automatic set_slot(input int s, input int x, input int y, input int w, input int h);
    obstacle_start[s]  = 1'b1;
    obstacle_x_pos[s]  = 11'(x);
    obstacle_y_pos[s]  = 10'(y);
    obstacle_width[s]  = 10'(w);
    obstacle_height[s] = 10'(h);
  endtask

  task automatic apply_vec(input vec_t v);
    default_slots();
    set_trex(v.tx, v.ty, v.tw, v.th);
    if (v.sa >= 0) set_slot(v.sa, v.ax, v.ay, v.aw, v.ah);
    if (v.sb >= 0) set_slot(v.sb, v.bx, v.by, v.bw, v.bh);
  endtask

  task automatic do_clear();
    @(negedge clk) clear = 1'b1;
    @(negedge clk) clear = 1'b0;
  endtask

  // Returns 1 ns after the edge (E0) that samples scan.
  task automatic start_scan();
    @(negedge clk) scan = 1'b1;
    @(posedge clk);
    #1 scan = 1'b0;
  endtask

  // Edges after E0 until done is seen; 40 means it never came.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask

  task automatic count_done(input int cycles, output int cnt);
    cnt = 0;
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk);
      #1 if (done) cnt++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, cnt;

    vecs[0]  = '{"empty",         50, 100, 44, 47, -1,   0,   0,  0,  0, -1,  0,   0,  0,  0, 0, 0, 7};
    vecs[1]  = '{"slot3_hit",     50, 100, 44, 47,  3,  60, 110, 17, 35, -1,  0,   0,  0,  0, 1, 3, 4};
    vecs[2]  = '{"touch1_hit5",   50, 100, 44, 47,  1,  92, 100, 20, 47,  5, 60, 110, 17, 35, 1, 5, 6};
    vecs[3]  = '{"raw_gap",       50, 100, 44, 47,  2,  95, 100, 20, 47, -1,  0,   0,  0,  0, 0, 0, 7};
    vecs[4]  = '{"inset_touch",   50, 100, 44, 47,  2,  90, 100, 20, 47, -1,  0,   0,  0,  0, 0, 0, 7};
    vecs[5]  = '{"inset_overlap", 50, 100, 44, 47,  2,  89, 100, 20, 47, -1,  0,   0,  0,  0, 1, 2, 3};
    vecs[6]  = '{"neg_x_hit",      0, 100, 44, 47,  0, -20, 100, 25, 47, -1,  0,   0,  0,  0, 1, 0, 1};
    vecs[7]  = '{"neg_x_miss",     0, 100, 44, 47,  0, -30, 100, 25, 47, -1,  0,   0,  0,  0, 0, 0, 7};
    vecs[8]  = '{"width_clamp",   50, 100, 44, 47,  4,  60, 110,  4, 35, -1,  0,   0,  0,  0, 0, 0, 7};
    vecs[9]  = '{"width_min",     50, 100, 44, 47,  4,  60, 110,  5, 35, -1,  0,   0,  0,  0, 1, 4, 5};
    vecs[10] = '{"y_below",       50, 100, 44, 47,  6,  60, 150, 17, 35, -1,  0,   0,  0,  0, 0, 0, 7};
    vecs[11] = '{"last_slot_hit", 50, 100, 44, 47,  6,  60, 140, 17, 35, -1,  0,   0,  0,  0, 1, 6, 7};
    vecs[12] = '{"lowest_wins",   50, 100, 44, 47,  2,  60, 110, 17, 35,  4, 60, 110, 17, 35, 1, 2, 3};
    vecs[13] = '{"trex_h_clamp",  50, 100, 44,  4,  3,  60, 100, 17, 35, -1,  0,   0,  0,  0, 0, 0, 7};

    rst   = 1'b0;
    scan  = 1'b0;
    clear = 1'b0;
    default_slots();
    set_trex(50, 100, 44, 47);
    #1;
    chk("reset_outputs", int'({busy, done, crash, hit_index}), 0);
    #20;
    @(negedge clk) rst = 1'b1;

    // First scan after reset release, issued on the first available edge.
    start_scan();
    chk("first_scan_busy", int'(busy), 1);
    wait_done(lat);
    chk("first_scan_latency", lat, 7);
    chk("first_scan_crash", int'(crash), 0);

    for (int i = 0; i < NV; i++) begin
      do_clear();
      apply_vec(vecs[i]);
      start_scan();
      chk({vecs[i].name, "_busy"}, int'(busy), 1);
      wait_done(lat);
      chk({vecs[i].name, "_latency"}, lat, vecs[i].exp_lat);
      chk({vecs[i].name, "_crash"}, int'(crash), vecs[i].exp_crash);
      chk({vecs[i].name, "_hit_index"}, int'(hit_index), vecs[i].exp_idx);
      @(posedge clk);
      #1;
      chk({vecs[i].name, "_done_pulse"}, int'({done, busy}), 0);
    end

    // scan re-pulsed two cycles into a scan is ignored.
    do_clear();
    default_slots();
    set_trex(50, 100, 44, 47);
    start_scan();
    @(posedge clk);
    @(negedge clk) scan = 1'b1;
    @(posedge clk);
    #1 scan = 1'b0;
    count_done(20, cnt);
    chk("rescan_done_count", cnt, 1);

    // clear mid-scan aborts without a done pulse.
    start_scan();
    repeat (2) @(posedge clk);
    @(negedge clk) clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_crash", int'(crash), 0);
    count_done(12, cnt);
    chk("abort_done_count", cnt, 0);

    // clear wins over a hit sampled on the same edge (slot 3 hits on E4).
    default_slots();
    set_slot(3, 60, 110, 17, 35);
    start_scan();
    repeat (3) @(posedge clk);
    @(negedge clk) clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    chk("clear_vs_hit_crash", int'(crash), 0);
    chk("clear_vs_hit_busy", int'(busy), 0);
    count_done(10, cnt);
    chk("clear_vs_hit_done_count", cnt, 0);

    // A sticky crash blocks new scans.
    start_scan();
    wait_done(lat);
    chk("sticky_latency", lat, 4);
    default_slots();
    start_scan();
    chk("sticky_scan_ignored", int'(busy), 0);
    count_done(10, cnt);
    chk("sticky_done_count", cnt, 0);
    chk("sticky_crash", int'(crash), 1);
    chk("sticky_hit_index", int'(hit_index), 3);

    // Asynchronous reset between edges clears the crash immediately.
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("async_rst_crash", int'({crash, hit_index}), 0);
    @(negedge clk) rst = 1'b1;

    // Asynchronous reset mid-scan, then a normal scan.
    start_scan();
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("async_rst_midscan", int'({busy, done, crash, hit_index}), 0);
    @(negedge clk) begin
      rst  = 1'b1;
      scan = 1'b1;
    end
    @(posedge clk);
    #1 scan = 1'b0;
    chk("post_rst_busy", int'(busy), 1);
    wait_done(lat);
    chk("post_rst_latency", lat, 7);
    chk("post_rst_crash", int'(crash), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
